// File: rtl/alu_pkg.sv
// Shared constants and types for the multi-cycle 8-bit ALU sequencer.
package alu_pkg;

   localparam int WIDTH     = 8;
   localparam int MUL_ITERS = 8;

   typedef enum logic [2:0] {
      ADD   = 3'd0,
      SUB   = 3'd1,
      AND   = 3'd2,
      OR    = 3'd3,
      XOR   = 3'd4,
      SHL   = 3'd5,
      MUL   = 3'd6,
      PASSB = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational single-cycle ALU ops (ADD, SUB, AND, OR, XOR, PASSB).
module alu_comb
   import alu_pkg::*;
(
   input  opcode_t          i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_zero
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   // The extra top bit of the unsigned difference is the borrow (a < b).
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   // NOTE: every output gets a default first so no path through the case leaves a latch.
   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      case (i_op)
         ADD:     {o_carry, o_result} = w_sum;
         SUB:     {o_carry, o_result} = w_diff;
         AND:     o_result = i_a & i_b;
         OR:      o_result = i_a | i_b;
         XOR:     o_result = i_a ^ i_b;
         PASSB:   o_result = i_b;
         default: o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Start/busy ALU sequencer: single-cycle ops via alu_comb, SHL and MUL iterated
// one bit per cycle; result and flags registered once, announced by a save pulse.
module alu_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] alu_out,
   output logic             save,
   output logic             flag_z,
   output logic             flag_c
);
   import alu_pkg::*;

   alu_state_t         r_state, w_state_next;
   opcode_t            r_op;
   logic [WIDTH-1:0]   r_a, r_b;
   logic [2:0]         r_cnt;
   logic [2*WIDTH-1:0] r_work;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_alu_out;
   logic               r_flag_z, r_flag_c;

   logic [WIDTH-1:0]   w_comb_res;
   logic               w_comb_c, w_comb_z;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2:0]         w_shamt;
   logic [WIDTH-1:0]   w_result;
   logic               w_carry, w_zero, w_last;

   alu_comb u_alu_comb (
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_result (w_comb_res),
      .o_carry  (w_comb_c),
      .o_zero   (w_comb_z)
   );

   assign w_shamt = r_b[2:0];

   // r_work doubles as the SHL shift register and the MUL multiplicand (a << r_cnt).
   always_comb begin
      w_acc_next = r_acc + (r_b[r_cnt] ? r_work : '0);
      w_last     = 1'b1;
      w_result   = w_comb_res;
      w_carry    = w_comb_c;
      w_zero     = w_comb_z;
      case (r_op)
         SHL: begin
            if (w_shamt == 3'd0) begin
               w_result = r_a;
               w_carry  = 1'b0;
            end else begin
               w_last   = (r_cnt == w_shamt - 3'd1);
               w_result = {r_work[WIDTH-2:0], 1'b0};
               w_carry  = r_work[WIDTH-1];
            end
            w_zero = (w_result == '0);
         end
         MUL: begin
            w_last   = (r_cnt == 3'(MUL_ITERS - 1));
            w_result = w_acc_next[WIDTH-1:0];
            w_carry  = |w_acc_next[2*WIDTH-1:WIDTH];
            w_zero   = (w_result == '0);
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = EXEC;
         EXEC:    if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_next;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op      <= ADD;
         r_a       <= '0;
         r_b       <= '0;
         r_cnt     <= '0;
         r_work    <= '0;
         r_acc     <= '0;
         r_alu_out <= '0;
         r_flag_z  <= 1'b0;
         r_flag_c  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_op   <= opcode_t'(opcode);
                  r_a    <= a;
                  r_b    <= b;
                  r_cnt  <= '0;
                  r_work <= {{WIDTH{1'b0}}, a};
                  r_acc  <= '0;
               end
            end
            EXEC: begin
               r_cnt  <= r_cnt + 3'd1;
               r_work <= r_work << 1;
               r_acc  <= w_acc_next;
               if (w_last) begin
                  r_alu_out <= w_result;
                  r_flag_z  <= w_zero;
                  r_flag_c  <= w_carry;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy    = (r_state != IDLE);
   assign save    = (r_state == DONE);
   assign alu_out = r_alu_out;
   assign flag_z  = r_flag_z;
   assign flag_c  = r_flag_c;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: latency, results, flags, ignored start, async reset.
module tb_alu_sequencer;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [2:0] opcode;
   logic [7:0] a, b;
   logic       busy;
   logic [7:0] alu_out;
   logic       save;
   logic       flag_z, flag_c;

   int         vectors     = 0;
   int         miscompares = 0;
   int         n_saves;
   int         save_cyc;
   logic [7:0] cap_out;
   logic       cap_c;

   alu_sequencer #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .opcode  (opcode),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .alu_out (alu_out),
      .save    (save),
      .flag_z  (flag_z),
      .flag_c  (flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op, time its save pulse (bounded), then check result, flags and return to idle.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] va,
                         input logic [7:0] vb, input int exp_lat, input logic [7:0] exp_out,
                         input logic exp_c, input logic exp_z);
      int lat;
      @(negedge clk);
      start = 1'b1; opcode = op; a = va; b = vb;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy"}, 16'(busy), 16'd1);
      lat = 0;
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         @(negedge clk);
         if (save) lat = i;
      end
      check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
      check({tag, "_out"}, 16'(alu_out), 16'(exp_out));
      check({tag, "_c"}, 16'(flag_c), 16'(exp_c));
      check({tag, "_z"}, 16'(flag_z), 16'(exp_z));
      @(negedge clk);
      check({tag, "_save_lo"}, 16'(save), 16'd0);
      check({tag, "_idle"}, 16'(busy), 16'd0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; opcode = 3'd0; a = 8'h00; b = 8'h00;
      #2;
      check("rst_busy", 16'(busy), 16'd0);
      check("rst_save", 16'(save), 16'd0);
      check("rst_out", 16'(alu_out), 16'h00);
      check("rst_flags", 16'({flag_z, flag_c}), 16'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      run_op("add",   3'd0, 8'hF0, 8'h20, 1, 8'h10, 1'b1, 1'b0);
      run_op("sub1",  3'd1, 8'h05, 8'h07, 1, 8'hFE, 1'b1, 1'b0);
      run_op("sub2",  3'd1, 8'h07, 8'h07, 1, 8'h00, 1'b0, 1'b1);
      run_op("mul1",  3'd6, 8'h12, 8'h10, 8, 8'h20, 1'b1, 1'b0);
      run_op("mul2",  3'd6, 8'h0F, 8'h03, 8, 8'h2D, 1'b0, 1'b0);
      run_op("shl3",  3'd5, 8'h81, 8'h03, 3, 8'h08, 1'b0, 1'b0);
      run_op("shl1",  3'd5, 8'h81, 8'h01, 1, 8'h02, 1'b1, 1'b0);
      run_op("shl0",  3'd5, 8'h5A, 8'h08, 1, 8'h5A, 1'b0, 1'b0);
      run_op("shl7",  3'd5, 8'h03, 8'h07, 7, 8'h80, 1'b1, 1'b0);
      run_op("and",   3'd2, 8'hF0, 8'h3C, 1, 8'h30, 1'b0, 1'b0);
      run_op("or",    3'd3, 8'hF0, 8'h0F, 1, 8'hFF, 1'b0, 1'b0);
      run_op("xor",   3'd4, 8'hAA, 8'hAA, 1, 8'h00, 1'b0, 1'b1);
      run_op("passb", 3'd7, 8'hFF, 8'h5A, 1, 8'h5A, 1'b0, 1'b0);
      run_op("add_z", 3'd0, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b1);

      // MUL 0x13 x 0x11 = 0x143 with a competing ADD request pulsed mid-flight
      @(negedge clk);
      start = 1'b1; opcode = 3'd6; a = 8'h13; b = 8'h11;
      @(negedge clk);
      start = 1'b0;
      n_saves = 0; save_cyc = 0; cap_out = 8'h00; cap_c = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 3) begin start = 1'b1; opcode = 3'd0; a = 8'h01; b = 8'h01; end
         if (i == 4) start = 1'b0;
         if (save) begin n_saves++; save_cyc = i; cap_out = alu_out; cap_c = flag_c; end
      end
      check("ign_nsave", 16'(n_saves), 16'd1);
      check("ign_cyc", 16'(save_cyc), 16'd8);
      check("ign_out", 16'(cap_out), 16'h43);
      check("ign_c", 16'(cap_c), 16'd1);
      check("ign_hold", 16'(alu_out), 16'h43);
      check("ign_idle", 16'(busy), 16'd0);

      // Reset asserted at MUL cycle 4
      @(negedge clk);
      start = 1'b1; opcode = 3'd6; a = 8'hFF; b = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", 16'(busy), 16'd1);
      reset_n = 1'b0;
      #1;
      check("ar_busy", 16'(busy), 16'd0);
      check("ar_save", 16'(save), 16'd0);
      check("ar_out", 16'(alu_out), 16'h00);
      check("ar_z", 16'(flag_z), 16'd0);
      check("ar_c", 16'(flag_c), 16'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      n_saves = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (save || busy) n_saves++;
      end
      check("post_rst_quiet", 16'(n_saves), 16'd0);
      run_op("add_rst", 3'd0, 8'h01, 8'h01, 1, 8'h02, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
